// File: rtl/mips_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mips_alu_pkg
// Brief   : ALU control codes, ALUOp encodings and funct/opcode values shared
//           by the ALU issue stage and its control decoder.
// Revision: 1.0 - initial release
// ============================================================================
package mips_alu_pkg;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_ITYPE = 2'b11
    } aluop_e;

    localparam logic [3:0] c_ctrl_and = 4'b0000;
    localparam logic [3:0] c_ctrl_or  = 4'b0001;
    localparam logic [3:0] c_ctrl_add = 4'b0010;
    localparam logic [3:0] c_ctrl_sub = 4'b0110;
    localparam logic [3:0] c_ctrl_slt = 4'b0111;
    localparam logic [3:0] c_ctrl_nor = 4'b1100;
    localparam logic [3:0] c_ctrl_bad = 4'b1111;

    localparam logic [5:0] c_funct_add  = 6'b100000;
    localparam logic [5:0] c_funct_addu = 6'b100001;
    localparam logic [5:0] c_funct_sub  = 6'b100010;
    localparam logic [5:0] c_funct_subu = 6'b100011;
    localparam logic [5:0] c_funct_and  = 6'b100100;
    localparam logic [5:0] c_funct_or   = 6'b100101;
    localparam logic [5:0] c_funct_nor  = 6'b100111;
    localparam logic [5:0] c_funct_slt  = 6'b101010;

    localparam logic [5:0] c_op_addi  = 6'b001000;
    localparam logic [5:0] c_op_addiu = 6'b001001;
    localparam logic [5:0] c_op_slti  = 6'b001010;
    localparam logic [5:0] c_op_andi  = 6'b001100;
    localparam logic [5:0] c_op_ori   = 6'b001101;

endpackage : mips_alu_pkg
`default_nettype wire

// File: rtl/alu_issue_stage_if.sv
`default_nettype none
// ============================================================================
// Module  : alu_issue_stage_if
// Brief   : Upstream instruction, forwarding and downstream ALU bundle of the
//           ID/EX issue stage. master = testbench/upstream, slave = stage.
// Revision: 1.0 - initial release
// ============================================================================
interface alu_issue_stage_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            alu_op;
    logic [5:0]            opcode;
    logic [5:0]            funct;
    logic [REG_ADDR_W-1:0] rs_addr;
    logic [REG_ADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0]     rs_data;
    logic [DATA_W-1:0]     rt_data;
    logic [15:0]           imm;
    logic                  alu_src;
    logic [REG_ADDR_W-1:0] dest_addr_in;
    logic                  dest_we_in;
    logic                  mem_we;
    logic [REG_ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0]     mem_data;
    logic                  wb_we;
    logic [REG_ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0]     wb_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [3:0]            alu_control;
    logic [DATA_W-1:0]     operand_a;
    logic [DATA_W-1:0]     operand_b;
    logic [DATA_W-1:0]     store_data;
    logic [REG_ADDR_W-1:0] dest_addr;
    logic                  dest_we;
    logic                  illegal;

    modport master (
        output flush, in_valid, alu_op, opcode, funct, rs_addr, rt_addr,
               rs_data, rt_data, imm, alu_src, dest_addr_in, dest_we_in,
               mem_we, mem_addr, mem_data, wb_we, wb_addr, wb_data, out_ready,
        input  in_ready, out_valid, alu_control, operand_a, operand_b,
               store_data, dest_addr, dest_we, illegal
    );

    modport slave (
        input  flush, in_valid, alu_op, opcode, funct, rs_addr, rt_addr,
               rs_data, rt_data, imm, alu_src, dest_addr_in, dest_we_in,
               mem_we, mem_addr, mem_data, wb_we, wb_addr, wb_data, out_ready,
        output in_ready, out_valid, alu_control, operand_a, operand_b,
               store_data, dest_addr, dest_we, illegal
    );

endinterface : alu_issue_stage_if
`default_nettype wire

// File: rtl/alu_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module  : alu_ctrl_decode
// Brief   : Combinational ALUOp/funct/opcode to 4-bit ALU control decoder,
//           flagging unsupported encodings and zero-extending immediates.
// Revision: 1.0 - initial release
// ============================================================================
module alu_ctrl_decode
    import mips_alu_pkg::*;
(
    input  wire logic [1:0] alu_op,
    input  wire logic [5:0] opcode,
    input  wire logic [5:0] funct,
    output logic      [3:0] alu_control,
    output logic            illegal,
    output logic            zero_ext
);

    always_comb begin
        alu_control = c_ctrl_bad;
        illegal     = 1'b0;
        zero_ext    = 1'b0;
        case (aluop_e'(alu_op))
            ALUOP_ADD: alu_control = c_ctrl_add;
            ALUOP_SUB: alu_control = c_ctrl_sub;
            ALUOP_RTYPE: begin
                case (funct)
                    c_funct_add, c_funct_addu: alu_control = c_ctrl_add;
                    c_funct_sub, c_funct_subu: alu_control = c_ctrl_sub;
                    c_funct_and:               alu_control = c_ctrl_and;
                    c_funct_or:                alu_control = c_ctrl_or;
                    c_funct_nor:               alu_control = c_ctrl_nor;
                    c_funct_slt:               alu_control = c_ctrl_slt;
                    default:                   illegal     = 1'b1;
                endcase
            end
            ALUOP_ITYPE: begin
                case (opcode)
                    c_op_addi, c_op_addiu: alu_control = c_ctrl_add;
                    c_op_slti:             alu_control = c_ctrl_slt;
                    c_op_andi: begin
                        alu_control = c_ctrl_and;
                        zero_ext    = 1'b1;
                    end
                    c_op_ori: begin
                        alu_control = c_ctrl_or;
                        zero_ext    = 1'b1;
                    end
                    default:               illegal     = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule : alu_ctrl_decode
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module  : alu_issue_stage
// Brief   : ID/EX stage register with ALU control decode, MEM/WB operand
//           forwarding and valid/ready handshake with synchronous flush.
// Revision: 1.0 - initial release
// ============================================================================
module alu_issue_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    alu_issue_stage_if.slave bus
);

    logic [3:0]            w_alu_control;
    logic                  w_illegal;
    logic                  w_zero_ext;
    logic                  w_in_ready;
    logic                  w_capture;
    logic [DATA_W-1:0]     w_fwd_rs;
    logic [DATA_W-1:0]     w_fwd_rt;
    logic [DATA_W-1:0]     w_ext_imm;

    logic                  r_valid;
    logic [3:0]            r_alu_control;
    logic [DATA_W-1:0]     r_operand_a;
    logic [DATA_W-1:0]     r_operand_b;
    logic [DATA_W-1:0]     r_store_data;
    logic [REG_ADDR_W-1:0] r_dest_addr;
    logic                  r_dest_we;
    logic                  r_illegal;

    // Nearest producer wins; register 0 is hardwired and never forwarded.
    function automatic logic [DATA_W-1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] src,
        input logic [DATA_W-1:0]     rf_data,
        input logic                  mem_we,
        input logic [REG_ADDR_W-1:0] mem_addr,
        input logic [DATA_W-1:0]     mem_data,
        input logic                  wb_we,
        input logic [REG_ADDR_W-1:0] wb_addr,
        input logic [DATA_W-1:0]     wb_data
    );
        logic src_nz;
        src_nz = (src != '0);
        if (mem_we && (mem_addr == src) && src_nz) begin
            return mem_data;
        end else if (wb_we && (wb_addr == src) && src_nz) begin
            return wb_data;
        end
        return rf_data;
    endfunction

    alu_ctrl_decode u_alu_ctrl_decode (
        .alu_op      (bus.alu_op),
        .opcode      (bus.opcode),
        .funct       (bus.funct),
        .alu_control (w_alu_control),
        .illegal     (w_illegal),
        .zero_ext    (w_zero_ext)
    );

    always_comb begin
        w_fwd_rs = fwd_sel(bus.rs_addr, bus.rs_data, bus.mem_we, bus.mem_addr,
                           bus.mem_data, bus.wb_we, bus.wb_addr, bus.wb_data);
        w_fwd_rt = fwd_sel(bus.rt_addr, bus.rt_data, bus.mem_we, bus.mem_addr,
                           bus.mem_data, bus.wb_we, bus.wb_addr, bus.wb_data);
        w_ext_imm = w_zero_ext ? {{(DATA_W-16){1'b0}}, bus.imm}
                               : {{(DATA_W-16){bus.imm[15]}}, bus.imm};
    end

    assign w_in_ready = !bus.flush && (!r_valid || bus.out_ready);
    assign w_capture  = bus.in_valid && w_in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_valid <= 1'b1;
        end else if (bus.out_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Payload only moves on capture so held entries and bubbles stay stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_control <= '0;
            r_operand_a   <= '0;
            r_operand_b   <= '0;
            r_store_data  <= '0;
            r_dest_addr   <= '0;
            r_dest_we     <= 1'b0;
            r_illegal     <= 1'b0;
        end else if (w_capture) begin
            r_alu_control <= w_alu_control;
            r_operand_a   <= w_fwd_rs;
            r_operand_b   <= bus.alu_src ? w_ext_imm : w_fwd_rt;
            r_store_data  <= w_fwd_rt;
            r_dest_addr   <= bus.dest_addr_in;
            r_dest_we     <= bus.dest_we_in && !w_illegal;
            r_illegal     <= w_illegal;
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = r_valid;
    assign bus.alu_control = r_alu_control;
    assign bus.operand_a   = r_operand_a;
    assign bus.operand_b   = r_operand_b;
    assign bus.store_data  = r_store_data;
    assign bus.dest_addr   = r_dest_addr;
    assign bus.dest_we     = r_dest_we;
    assign bus.illegal     = r_illegal;

endmodule : alu_issue_stage
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_issue_stage
// Brief   : Directed self-checking bench for alu_issue_stage with a
//           transaction-level reference model compared every cycle.
// Revision: 1.0 - initial release
// ============================================================================
module tb_alu_issue_stage;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    alu_issue_stage_if #(.DATA_W(32), .REG_ADDR_W(5)) bus ();

    alu_issue_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference entry: what the ALU should currently be looking at.
    logic        m_valid;
    logic [3:0]  m_ctrl;
    logic [31:0] m_a, m_b, m_sd;
    logic [4:0]  m_dest;
    logic        m_dwe, m_ill;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {illegal, code} from the documented decode table.
    function automatic logic [4:0] ref_decode(input logic [1:0] op, input logic [5:0] opc,
                                               input logic [5:0] fn);
        if (op == 2'd0) return 5'h02;
        if (op == 2'd1) return 5'h06;
        if (op == 2'd2) begin
            case (fn)
                6'h20, 6'h21: return 5'h02;
                6'h22, 6'h23: return 5'h06;
                6'h24:        return 5'h00;
                6'h25:        return 5'h01;
                6'h27:        return 5'h0C;
                6'h2A:        return 5'h07;
                default:      return 5'h1F;
            endcase
        end
        case (opc)
            6'h08, 6'h09: return 5'h02;
            6'h0C:        return 5'h00;
            6'h0D:        return 5'h01;
            6'h0A:        return 5'h07;
            default:      return 5'h1F;
        endcase
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [4:0] src, input logic [31:0] rf);
        if (src != 0 && bus.mem_we && bus.mem_addr == src) return bus.mem_data;
        if (src != 0 && bus.wb_we && bus.wb_addr == src) return bus.wb_data;
        return rf;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_ctrl  <= 4'h0;
            m_a     <= 32'h0;
            m_b     <= 32'h0;
            m_sd    <= 32'h0;
            m_dest  <= 5'h0;
            m_dwe   <= 1'b0;
            m_ill   <= 1'b0;
        end else begin
            automatic logic        acc = bus.in_valid && !bus.flush && (!m_valid || bus.out_ready);
            automatic logic [4:0]  dec = ref_decode(bus.alu_op, bus.opcode, bus.funct);
            automatic logic        zx  = (bus.alu_op == 2'd3) && (bus.opcode == 6'h0C || bus.opcode == 6'h0D);
            automatic logic [31:0] ext = zx ? 32'(bus.imm) : 32'(signed'(bus.imm));
            if (acc) begin
                m_valid <= 1'b1;
                m_ctrl  <= dec[3:0];
                m_ill   <= dec[4];
                m_a     <= ref_fwd(bus.rs_addr, bus.rs_data);
                m_b     <= bus.alu_src ? ext : ref_fwd(bus.rt_addr, bus.rt_data);
                m_sd    <= ref_fwd(bus.rt_addr, bus.rt_data);
                m_dest  <= bus.dest_addr_in;
                m_dwe   <= bus.dest_we_in && !dec[4];
            end else if (bus.flush || bus.out_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready", 32'(bus.in_ready), 32'(!bus.flush && (!m_valid || bus.out_ready)));
        chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
        chk("alu_control", 32'(bus.alu_control), 32'(m_ctrl));
        chk("operand_a", bus.operand_a, m_a);
        chk("operand_b", bus.operand_b, m_b);
        chk("store_data", bus.store_data, m_sd);
        chk("dest", {bus.dest_we, bus.illegal, bus.dest_addr}, {m_dwe, m_ill, m_dest});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [1:0] op, input logic [5:0] opc, input logic [5:0] fn,
                             input logic [4:0] rs, input logic [4:0] rt,
                             input logic [31:0] rsd, input logic [31:0] rtd,
                             input logic [15:0] im, input logic src,
                             input logic [4:0] dst, input logic dwe);
        bus.alu_op = op;  bus.opcode = opc; bus.funct = fn;
        bus.rs_addr = rs; bus.rt_addr = rt; bus.rs_data = rsd; bus.rt_data = rtd;
        bus.imm = im;     bus.alu_src = src;
        bus.dest_addr_in = dst; bus.dest_we_in = dwe;
    endtask

    task automatic issue();
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
    endtask

    logic [5:0] functs [10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h3F};
    logic [5:0] opcs   [6]  = '{6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h04};

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.flush = 0; bus.in_valid = 0; bus.out_ready = 1;
        bus.mem_we = 0; bus.mem_addr = 0; bus.mem_data = 0;
        bus.wb_we = 0;  bus.wb_addr = 0;  bus.wb_data = 0;
        set_instr(2'd0, 6'h0, 6'h0, 5'd0, 5'd0, 32'h0, 32'h0, 16'h0, 1'b0, 5'd0, 1'b0);
        step();
        step();
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_alu_control", 32'(bus.alu_control), 32'h0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
        rst_n = 1'b1;
        step();

        set_instr(2'd2, 6'h0, 6'b100010, 5'd5, 5'd6, 32'd9, 32'd4, 16'h0, 1'b0, 5'd7, 1'b1);
        issue();
        chk("sub_valid", 32'(bus.out_valid), 32'h1);
        chk("sub_ctrl", 32'(bus.alu_control), 32'h6);
        chk("sub_a", bus.operand_a, 32'd9);
        chk("sub_b", bus.operand_b, 32'd4);

        bus.mem_we = 1; bus.mem_addr = 5'd3; bus.mem_data = 32'hAAAA;
        bus.wb_we = 1;  bus.wb_addr = 5'd3;  bus.wb_data = 32'hBBBB;
        set_instr(2'd2, 6'h0, 6'h20, 5'd3, 5'd0, 32'h1111, 32'h2222, 16'h0, 1'b0, 5'd8, 1'b1);
        issue();
        chk("fwd_mem_prio", bus.operand_a, 32'hAAAA);
        chk("fwd_rt_zero", bus.operand_b, 32'h2222);
        bus.mem_addr = 5'd4;
        set_instr(2'd0, 6'h0, 6'h0, 5'd3, 5'd4, 32'h1111, 32'h2222, 16'h0, 1'b0, 5'd8, 1'b1);
        issue();
        chk("fwd_wb", bus.operand_a, 32'hBBBB);
        chk("fwd_mem_rt", bus.store_data, 32'hAAAA);
        bus.mem_addr = 5'd0; bus.wb_addr = 5'd0;
        set_instr(2'd0, 6'h0, 6'h0, 5'd0, 5'd9, 32'h1234, 32'h5678, 16'h0, 1'b0, 5'd8, 1'b1);
        issue();
        chk("fwd_r0", bus.operand_a, 32'h1234);
        bus.mem_we = 0; bus.wb_we = 0;

        set_instr(2'd3, 6'b001100, 6'h0, 5'd1, 5'd2, 32'h10, 32'h20, 16'h8001, 1'b1, 5'd2, 1'b1);
        issue();
        chk("andi_b", bus.operand_b, 32'h00008001);
        chk("andi_ctrl", 32'(bus.alu_control), 32'h0);
        set_instr(2'd3, 6'b001000, 6'h0, 5'd1, 5'd2, 32'h10, 32'h20, 16'hFFFF, 1'b1, 5'd2, 1'b1);
        issue();
        chk("addi_b", bus.operand_b, 32'hFFFFFFFF);
        chk("addi_ctrl", 32'(bus.alu_control), 32'h2);

        for (int i = 0; i < 10; i++) begin
            set_instr(2'd2, 6'h0, functs[i], 5'(i + 1), 5'(i + 2), 32'(i * 3), 32'(i * 7),
                      16'h0, 1'b0, 5'(i), 1'b1);
            issue();
        end
        for (int i = 0; i < 6; i++) begin
            set_instr(2'd3, opcs[i], 6'h0, 5'(i + 1), 5'(i + 2), 32'(i * 5), 32'(i * 11),
                      16'h8000 | 16'(i), 1'b1, 5'(i), 1'b1);
            issue();
        end
        set_instr(2'd1, 6'h0, 6'h0, 5'd1, 5'd2, 32'h7, 32'h3, 16'h0, 1'b0, 5'd0, 1'b0);
        issue();
        chk("beq_ctrl", 32'(bus.alu_control), 32'h6);

        step();
        bus.out_ready = 0;
        set_instr(2'd0, 6'h0, 6'h0, 5'd1, 5'd2, 32'h100, 32'h1, 16'h0, 1'b0, 5'd3, 1'b1);
        issue();
        set_instr(2'd0, 6'h0, 6'h0, 5'd1, 5'd2, 32'h200, 32'h2, 16'h0, 1'b0, 5'd4, 1'b1);
        bus.in_valid = 1'b1;
        #1;
        chk("bp_in_ready", 32'(bus.in_ready), 32'h0);
        step();
        step();
        chk("bp_hold_valid", 32'(bus.out_valid), 32'h1);
        chk("bp_hold_a", bus.operand_a, 32'h100);
        bus.out_ready = 1;
        #1;
        chk("bp_release_ready", 32'(bus.in_ready), 32'h1);
        step();
        bus.in_valid = 1'b0;
        chk("bp_next_a", bus.operand_a, 32'h200);

        bus.flush = 1; bus.in_valid = 1;
        #1;
        chk("flush_in_ready", 32'(bus.in_ready), 32'h0);
        step();
        bus.flush = 0; bus.in_valid = 0;
        chk("flush_valid", 32'(bus.out_valid), 32'h0);

        set_instr(2'd2, 6'h0, 6'h00, 5'd1, 5'd2, 32'h5, 32'h6, 16'h0, 1'b0, 5'd9, 1'b1);
        issue();
        chk("ill_ctrl", 32'(bus.alu_control), 32'hF);
        chk("ill_flag", 32'(bus.illegal), 32'h1);
        chk("ill_dest_we", 32'(bus.dest_we), 32'h0);

        bus.out_ready = 0;
        set_instr(2'd0, 6'h0, 6'h0, 5'd1, 5'd2, 32'h300, 32'h3, 16'h0, 1'b0, 5'd5, 1'b1);
        issue();
        bus.flush = 1;
        step();
        bus.flush = 0;
        chk("flush_hold_valid", 32'(bus.out_valid), 32'h0);
        issue();
        step();
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(bus.out_valid), 32'h0);
        chk("midrst_a", bus.operand_a, 32'h0);
        step();
        rst_n = 1'b1;
        #1;
        chk("postrst_ready", 32'(bus.in_ready), 32'h1);
        bus.out_ready = 1;
        set_instr(2'd2, 6'h0, 6'h25, 5'd1, 5'd2, 32'h400, 32'h4, 16'h0, 1'b0, 5'd6, 1'b1);
        issue();
        chk("postrst_ctrl", 32'(bus.alu_control), 32'h1);
        chk("postrst_a", bus.operand_a, 32'h400);
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_alu_issue_stage
`default_nettype wire
